// File: rtl/pe_onehot_encoder_queue_if.sv
// Output side of the one-hot to binary encoder queue: one binary index and its
// one-hot copy, presented with a valid/ready handshake.
interface pe_onehot_encoder_queue_if #(
  parameter int ADDR_WIDTH = 3
);
  logic                         out_valid;
  logic                         out_ready;
  logic [ADDR_WIDTH-1:0]        out_addr;
  logic [(1<<ADDR_WIDTH)-1:0]   out_onehot;

  // Encoder drives the index stream and samples ready
  modport master (
    output out_valid,
    output out_addr,
    output out_onehot,
    input  out_ready
  );

  // Consumer (writeback, address mux) accepts indices
  modport slave (
    input  out_valid,
    input  out_addr,
    input  out_onehot,
    output out_ready
  );
endinterface

// File: rtl/pe_onehot_encoder_queue.sv
// Collects one-hot/multi-hot request pulses from the PE array into a pending
// register and hands them out one binary index at a time. Winner selection is
// lowest-index-first or round-robin. All outputs come straight from flops.
module pe_onehot_encoder_queue #(
  parameter int ADDR_WIDTH  = 3,
  parameter bit ROUND_ROBIN = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [(1<<ADDR_WIDTH)-1:0]  req_i,
  input  logic                        flush_i,
  pe_onehot_encoder_queue_if.master   out_if,
  output logic [(1<<ADDR_WIDTH)-1:0]  pending_o,
  output logic                        overflow,
  output logic                        idle
);

  localparam int N = 1 << ADDR_WIDTH;

  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [N-1:0]           pending_q, pending_d;
  logic                   out_valid_q, out_valid_d;
  logic [ADDR_WIDTH-1:0]  out_addr_q, out_addr_d;
  logic [N-1:0]           out_onehot_q, out_onehot_d;
  logic                   overflow_q, overflow_d;
  logic [ADDR_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;
  logic                   idle_q, idle_d;

  logic                   accept;
  logic                   load;
  logic [ADDR_WIDTH-1:0]  sel;
  logic [N-1:0]           sel_oh;
  logic [N-1:0]           clr_mask;

  // First set bit of vec at or after start, searching upward and wrapping.
  // With start=0 this degenerates to plain lowest-index-first priority.
  function automatic logic [ADDR_WIDTH-1:0] pick_winner(
    input logic [N-1:0]          vec,
    input logic [ADDR_WIDTH-1:0] start
  );
    logic [ADDR_WIDTH-1:0] idx;
    logic [ADDR_WIDTH-1:0] win;
    logic                  found;
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = start + ADDR_WIDTH'(i);
      if (!found && vec[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

  // Next-state: load decision uses only registered pending, never same-cycle req_i
  always_comb begin
    accept   = out_valid_q & out_if.out_ready;
    load     = (pending_q != '0) & ((state_q == EMPTY) | accept);
    sel      = pick_winner(pending_q, ROUND_ROBIN ? rr_ptr_q : '0);
    sel_oh   = N'(1) << sel;
    clr_mask = load ? sel_oh : '0;

    // A re-request on the lane being loaded survives the clear and is legal
    pending_d  = (pending_q & ~clr_mask) | req_i;
    overflow_d = overflow_q | (|(req_i & pending_q & ~clr_mask));

    state_d      = state_q;
    out_valid_d  = out_valid_q;
    out_addr_d   = out_addr_q;
    out_onehot_d = out_onehot_q;
    rr_ptr_d     = rr_ptr_q;

    if (load) begin
      state_d      = HOLD;
      out_valid_d  = 1'b1;
      out_addr_d   = sel;
      out_onehot_d = sel_oh;
      if (ROUND_ROBIN) begin
        rr_ptr_d = sel + ADDR_WIDTH'(1);
      end
    end else if (accept) begin
      // Drained: out_addr intentionally keeps its last value
      state_d      = EMPTY;
      out_valid_d  = 1'b0;
      out_onehot_d = '0;
    end

    idle_d = (state_d == EMPTY) & (pending_d == '0);
  end

  // State registers; flush clears like reset but keeps the round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= EMPTY;
      pending_q    <= '0;
      out_valid_q  <= 1'b0;
      out_addr_q   <= '0;
      out_onehot_q <= '0;
      overflow_q   <= 1'b0;
      rr_ptr_q     <= '0;
      idle_q       <= 1'b1;
    end else if (flush_i) begin
      state_q      <= EMPTY;
      pending_q    <= '0;
      out_valid_q  <= 1'b0;
      out_addr_q   <= '0;
      out_onehot_q <= '0;
      overflow_q   <= 1'b0;
      idle_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      out_valid_q  <= out_valid_d;
      out_addr_q   <= out_addr_d;
      out_onehot_q <= out_onehot_d;
      overflow_q   <= overflow_d;
      rr_ptr_q     <= rr_ptr_d;
      idle_q       <= idle_d;
    end
  end

  assign out_if.out_valid  = out_valid_q;
  assign out_if.out_addr   = out_addr_q;
  assign out_if.out_onehot = out_onehot_q;
  assign pending_o         = pending_q;
  assign overflow          = overflow_q;
  assign idle              = idle_q;

endmodule

// File: tb/tb_pe_onehot_encoder_queue.sv
// Bench for pe_onehot_encoder_queue: one fixed-priority and one round-robin
// instance. Stimulus pushes hand-computed indices into per-instance queues;
// negedge monitors pop and compare on every accepted output.
module tb_pe_onehot_encoder_queue;
  localparam int AW = 3;
  localparam int N  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_fp, req_rr;
  logic          flush_fp, flush_rr;
  logic [N-1:0]  pend_fp, pend_rr;
  logic          ovf_fp, ovf_rr;
  logic          idle_fp, idle_rr;

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] exp_fp[$];
  logic [AW-1:0] exp_rr[$];
  logic [AW-1:0] e_fp, e_rr;

  always #5 clk = ~clk;

  pe_onehot_encoder_queue_if #(.ADDR_WIDTH(AW)) fp_if();
  pe_onehot_encoder_queue_if #(.ADDR_WIDTH(AW)) rr_if();

  pe_onehot_encoder_queue #(.ADDR_WIDTH(AW), .ROUND_ROBIN(1'b0)) u_fp (
    .clk(clk), .rst(rst), .req_i(req_fp), .flush_i(flush_fp), .out_if(fp_if),
    .pending_o(pend_fp), .overflow(ovf_fp), .idle(idle_fp)
  );

  pe_onehot_encoder_queue #(.ADDR_WIDTH(AW), .ROUND_ROBIN(1'b1)) u_rr (
    .clk(clk), .rst(rst), .req_i(req_rr), .flush_i(flush_rr), .out_if(rr_if),
    .pending_o(pend_rr), .overflow(ovf_rr), .idle(idle_rr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: fixed-priority instance
  always @(negedge clk) begin
    if (!rst && fp_if.out_valid && fp_if.out_ready) begin
      if (exp_fp.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL fp_unexpected got addr=%0d expected none", fp_if.out_addr);
      end else begin
        e_fp = exp_fp.pop_front();
        chk("fp_addr", 32'(fp_if.out_addr), 32'(e_fp));
        chk("fp_onehot", 32'(fp_if.out_onehot), 32'(1) << e_fp);
      end
    end
  end

  // Monitor: round-robin instance
  always @(negedge clk) begin
    if (!rst && rr_if.out_valid && rr_if.out_ready) begin
      if (exp_rr.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rr_unexpected got addr=%0d expected none", rr_if.out_addr);
      end else begin
        e_rr = exp_rr.pop_front();
        chk("rr_addr", 32'(rr_if.out_addr), 32'(e_rr));
        chk("rr_onehot", 32'(rr_if.out_onehot), 32'(1) << e_rr);
      end
    end
  end

  initial begin
    rst = 1'b1;
    req_fp = 8'hFF; req_rr = 8'hFF;
    flush_fp = 1'b0; flush_rr = 1'b0;
    fp_if.out_ready = 1'b0;
    rr_if.out_ready = 1'b0;

    // Reset with all lanes requesting: requests must be discarded
    tick(2);
    rst = 1'b0;
    req_fp = '0; req_rr = '0;
    chk("rst_fp_valid", 32'(fp_if.out_valid), 0);
    chk("rst_fp_pending", 32'(pend_fp), 0);
    chk("rst_fp_overflow", 32'(ovf_fp), 0);
    chk("rst_fp_idle", 32'(idle_fp), 1);
    chk("rst_rr_valid", 32'(rr_if.out_valid), 0);
    chk("rst_rr_idle", 32'(idle_rr), 1);
    tick();
    chk("rst_fp_pending_after", 32'(pend_fp), 0);
    chk("rst_fp_valid_after", 32'(fp_if.out_valid), 0);

    // Fixed-priority drain of 1010_0100 -> 2,5,7 back to back
    fp_if.out_ready = 1'b1;
    req_fp = 8'hA4;
    exp_fp.push_back(3'd2); exp_fp.push_back(3'd5); exp_fp.push_back(3'd7);
    tick();
    req_fp = '0;
    chk("fp_drain_pending", 32'(pend_fp), 32'hA4);
    chk("fp_drain_latency", 32'(fp_if.out_valid), 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("fp_drain_valid", 32'(fp_if.out_valid), 1);
      tick();
    end
    chk("fp_drain_done_valid", 32'(fp_if.out_valid), 0);
    chk("fp_drain_idle", 32'(idle_fp), 1);

    // Backpressure on index 2 plus a legal re-request of lane 2
    fp_if.out_ready = 1'b0;
    req_fp = 8'h04;
    exp_fp.push_back(3'd2); exp_fp.push_back(3'd2);
    tick();
    req_fp = '0;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(fp_if.out_valid), 1);
      chk("bp_addr", 32'(fp_if.out_addr), 2);
      chk("bp_onehot", 32'(fp_if.out_onehot), 32'h04);
      req_fp = (i == 1) ? 8'h04 : 8'h00;
      tick();
    end
    chk("bp_pending", 32'(pend_fp), 32'h04);
    chk("bp_overflow", 32'(ovf_fp), 0);
    fp_if.out_ready = 1'b1;
    tick(3);
    chk("bp_idle", 32'(idle_fp), 1);

    // Overflow: lane 3 re-requested on the load edge (legal) then again while pending
    fp_if.out_ready = 1'b0;
    req_fp = 8'h08;
    exp_fp.push_back(3'd3); exp_fp.push_back(3'd3);
    tick();
    tick();
    chk("ovf_reload_overflow", 32'(ovf_fp), 0);
    chk("ovf_reload_pending", 32'(pend_fp), 32'h08);
    chk("ovf_reload_addr", 32'(fp_if.out_addr), 3);
    tick();
    req_fp = '0;
    chk("ovf_set", 32'(ovf_fp), 1);
    fp_if.out_ready = 1'b1;
    tick(3);
    chk("ovf_sticky", 32'(ovf_fp), 1);
    chk("ovf_drain_idle", 32'(idle_fp), 1);

    // Flush with simultaneous request on lane 0
    flush_fp = 1'b1;
    req_fp = 8'h01;
    tick();
    flush_fp = 1'b0;
    req_fp = '0;
    chk("flush_overflow", 32'(ovf_fp), 0);
    chk("flush_pending", 32'(pend_fp), 0);
    chk("flush_valid", 32'(fp_if.out_valid), 0);
    tick(3);
    chk("flush_no_emit", 32'(fp_if.out_valid), 0);
    chk("flush_idle", 32'(idle_fp), 1);

    // Round-robin: grant 5, then pending {1,6} -> 6 then 1
    rr_if.out_ready = 1'b1;
    req_rr = 8'h20;
    exp_rr.push_back(3'd5);
    tick();
    req_rr = '0;
    tick();
    req_rr = 8'h42;
    exp_rr.push_back(3'd6); exp_rr.push_back(3'd1);
    tick();
    req_rr = '0;
    tick(4);
    chk("rr_pair_idle", 32'(idle_rr), 1);

    // Move the pointer to 3 by granting lane 2, then all lanes at once
    req_rr = 8'h04;
    exp_rr.push_back(3'd2);
    tick();
    req_rr = '0;
    tick(3);
    req_rr = 8'hFF;
    for (int k = 0; k < 8; k++) exp_rr.push_back(AW'((k + 3) % 8));
    tick();
    req_rr = '0;
    tick();
    for (int i = 0; i < 8; i++) begin
      chk("rr_all_valid", 32'(rr_if.out_valid), 1);
      tick();
    end
    chk("rr_all_done_valid", 32'(rr_if.out_valid), 0);
    chk("rr_all_idle", 32'(idle_rr), 1);

    // Reset in HOLD with pending 30; pointer was 5 before reset
    rr_if.out_ready = 1'b0;
    req_rr = 8'h30;
    tick();
    req_rr = '0;
    tick();
    req_rr = 8'h10;
    tick();
    req_rr = '0;
    chk("mid_pending", 32'(pend_rr), 32'h30);
    chk("mid_valid", 32'(rr_if.out_valid), 1);
    chk("mid_addr", 32'(rr_if.out_addr), 4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", 32'(rr_if.out_valid), 0);
    chk("mid_rst_pending", 32'(pend_rr), 0);
    chk("mid_rst_addr", 32'(rr_if.out_addr), 0);
    chk("mid_rst_onehot", 32'(rr_if.out_onehot), 0);
    chk("mid_rst_overflow", 32'(ovf_rr), 0);
    chk("mid_rst_idle", 32'(idle_rr), 1);
    rr_if.out_ready = 1'b1;
    req_rr = 8'h30;
    exp_rr.push_back(3'd4); exp_rr.push_back(3'd5);
    tick();
    req_rr = '0;
    tick(4);
    chk("mid_after_idle", 32'(idle_rr), 1);

    chk("fp_queue_empty", 32'(exp_fp.size()), 0);
    chk("rr_queue_empty", 32'(exp_rr.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pe_onehot_encoder_queue.md
Name: pe_onehot_encoder_queue

Overview:
Converts one-hot/multi-hot request flags from the PE array (done flags, lane events) into a stream of binary indices. It is the inverse of the PE binary-to-one-hot decode path. Requests are captured into a pending register and arbitrated one at a time, either fixed-priority or round-robin. Each winner is presented as a binary address with a valid/ready handshake, so a single-index consumer such as a writeback or address mux can drain all requests without losing any.

Parameters:
ADDR_WIDTH, 3, index width; number of request lanes N = 2^ADDR_WIDTH (derived, not overridable)
ROUND_ROBIN, 0, 0 = fixed priority with lowest index first; 1 = round-robin starting after the last index handed to the output

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
req_i  input  N  request pulses; bit k high for one cycle = one event on lane k
flush_i  input  1  synchronous clear of pending, output and overflow state
out_valid  output  1  out_addr/out_onehot hold a valid index
out_ready  input  1  consumer accepts when out_valid & out_ready
out_addr  output  ADDR_WIDTH  binary index of the presented request
out_onehot  output  N  one-hot copy of out_addr; all-zero when out_valid=0
pending_o  output  N  current pending register, for debug/status
overflow  output  1  sticky: a request landed on an already-pending lane
idle  output  1  out_valid=0 and pending_o=0

Behaviour:
- Reset (rst=1 at a clock edge): pending=0, out_valid=0, out_addr=0, out_onehot=0, overflow=0, RR pointer=0, FSM=EMPTY, idle=1. Reset applies mid-operation and discards everything, including same-cycle req_i.
- Flush (flush_i=1, rst=0): same clearing as reset, except the RR pointer is kept. Same-cycle req_i is dropped.
- All outputs are registered. There is no combinational path from req_i or out_ready to any output.
- FSM states:
  - EMPTY, out_valid=0.
  - HOLD, out_valid=1; out_addr and out_onehot are stable while in HOLD until accepted.
- Load condition, evaluated on the registered pending value only (not same-cycle req_i):
  - load = (pending != 0) & (state==EMPTY | accept).
  - accept = out_valid & out_ready.
- On load:
  - sel = winning index.
  - out_addr <= sel; out_onehot <= 1<<sel; state <= HOLD.
  - If ROUND_ROBIN=1, RR pointer <= sel+1, wrapping mod N.
- On accept with pending=0: state <= EMPTY, out_valid <= 0, out_onehot <= 0. out_addr keeps its last value.
- Winner selection:
  - Fixed priority: lowest set index of pending.
  - Round-robin: first set index at or after the RR pointer, searching upward and wrapping from N-1 to 0.
- Pending update: pending_next = (pending & ~(load ? 1<<sel : 0)) | req_i.
  - A req_i on the lane being loaded in the same cycle stays pending. This is a legal re-request and is not an overflow.
- Overflow set condition: any k with req_i[k] & pending[k] & ~(load & sel==k). Overflow then holds until rst or flush_i.
- A request for the lane currently held in the output register, but not pending, is legal and is queued.
- Latency and throughput:
  - req_i sampled at edge t sets pending at t; out_valid rises at edge t+1, visible in the cycle after t+1.
  - With out_ready held high, one index per cycle (back-to-back, no bubble).
- Backpressure: while out_valid & ~out_ready, the outputs are frozen, pending keeps accumulating, and no load occurs.
- Boundary: all N lanes requesting at once drain in N consecutive cycles with ready=1. Index N-1 wraps the RR pointer to 0.

Test Plan:
- Reset/idle: assert rst 2 cycles with req_i=8'hFF -> out_valid=0, pending_o=0, overflow=0, idle=1 after release; req_i was ignored.
- Fixed priority drain: ADDR_WIDTH=3, ROUND_ROBIN=0, req_i=8'b1010_0100 for one cycle, out_ready=1 -> out_valid high for exactly 3 consecutive cycles with out_addr 2,5,7 and out_onehot 04,20,80, then idle=1.
- Backpressure plus re-request:
  - out_ready=0 for 5 cycles while out_addr=2 -> out_addr and out_onehot stable, out_valid=1.
  - Pulse req_i bit 2 during the hold -> pending_o[2]=1, overflow=0.
  - Raise ready -> addr 2 then 2 again.
- Round-robin: ROUND_ROBIN=1, grant lane 5, then pending {1,6} -> next 6 then 1. With all 8 lanes requesting after pointer=3 -> order 3,4,5,6,7,0,1,2.
- Overflow:
  - req_i bit 3 twice while pending[3]=1 and out_ready=0 -> overflow=1.
  - overflow stays 1 after draining.
  - flush_i with simultaneous req_i=8'h01 -> overflow=0, pending_o=0, out_valid=0, no index 0 emitted.
- Reset mid-HOLD: out_valid=1, pending=8'h30, rst pulse -> next cycle all outputs at reset values, RR pointer 0, first index after new req_i=8'h30 is 4.
